// File: rtl/rf_wport_arb.sv
// ---------------------------------------------------------------------------
// rf_wport_arb
//
// Arbitrates the single register-file write port between two sources:
//   * the pipeline WB stage, which cannot be back-pressured, and
//   * a multi-cycle unit, whose results queue in a small in-order FIFO.
// The WB stage normally wins. Queued results drain in cycles when WB is idle.
//
// Optional starvation guard (macro RF_ARB_STARVE_GUARD_EN):
//   A queued result may be denied for STARVE_LIMIT consecutive cycles. The
//   block then raises starve_stall for one cycle, and the FIFO head is
//   written in that cycle. Any WB write offered during that cycle is dropped,
//   and the sticky err flag is set. Without the macro, no counter is built,
//   starve_stall and err are tied low, and the FIFO drains only when WB is
//   idle.
//
// Parameters
//   DEPTH         FIFO entries (power of two, >= 2)
//   STARVE_LIMIT  consecutive denied cycles before a forced FIFO grant
//
// Ports
//   clk, reset                      clock, asynchronous active-low reset
//   wb_we/wb_reg/wb_data/wb_pc8     WB-stage write request
//   md_valid/md_reg/md_data/md_pc8  multi-cycle unit write request
//   md_ready                        FIFO can accept (from registered count)
//   rd1/rd2                         ID-stage source registers to look up
//   rd1_pending/rd2_pending         a queued or issuing write targets rdN
//   starve_stall                    WB must hold for this cycle
//   RegWrite/writereg/writedata/PC8 registered register-file write port
//   err                             sticky: a WB write was dropped
// ---------------------------------------------------------------------------
module rf_wport_arb #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_we,
    input  logic [4:0]  wb_reg,
    input  logic [31:0] wb_data,
    input  logic [31:0] wb_pc8,
    input  logic        md_valid,
    input  logic [4:0]  md_reg,
    input  logic [31:0] md_data,
    input  logic [31:0] md_pc8,
    output logic        md_ready,
    input  logic [4:0]  rd1,
    input  logic [4:0]  rd2,
    output logic        rd1_pending,
    output logic        rd2_pending,
    output logic        starve_stall,
    output logic        RegWrite,
    output logic [4:0]  writereg,
    output logic [31:0] writedata,
    output logic [31:0] PC8,
    output logic        err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_cfg_check
        $error("rf_wport_arb: DEPTH must be a power of two >= 2 and STARVE_LIMIT >= 1");
    end

    // FIFO storage and bookkeeping
    logic [4:0]    fifoReg_q  [DEPTH];
    logic [31:0]   fifoData_q [DEPTH];
    logic [31:0]   fifoPc8_q  [DEPTH];
    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [CW-1:0] count_q, count_d;

    // Registered write port
    logic          regWrite_q, regWrite_d;
    logic [4:0]    writeReg_q, writeReg_d;
    logic [31:0]   writeData_q, writeData_d;
    logic [31:0]   pc8_q, pc8_d;

    logic          fifoNotEmpty;
    logic          grantWb;
    logic          push;
    logic          pop;

    logic          hit1, hit2;
    logic [PW-1:0] offset;

    assign fifoNotEmpty = (count_q != '0);
    assign md_ready     = (count_q != CW'(DEPTH));
    assign push         = md_valid && md_ready;
    assign pop          = !grantWb && fifoNotEmpty;

`ifdef RF_ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] starveCnt_q, starveCnt_d;
    logic          starveStall_q, starveStall_d;
    logic          err_q, err_d;

    assign grantWb = wb_we && !starveStall_q;

    // The counter only advances while a queued entry is being passed over.
    // Hitting the limit schedules a one-cycle stall; the stall blocks WB,
    // so the head pops in that cycle and the pop clears the counter.
    always_comb begin
        starveCnt_d   = starveCnt_q;
        starveStall_d = 1'b0;
        err_d         = err_q | (wb_we & starveStall_q);
        if (pop || !fifoNotEmpty) begin
            starveCnt_d = '0;
        end else if (grantWb) begin
            starveCnt_d   = starveCnt_q + SW'(1);
            starveStall_d = (starveCnt_q == SW'(STARVE_LIMIT - 1));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starveCnt_q   <= '0;
            starveStall_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            starveCnt_q   <= starveCnt_d;
            starveStall_q <= starveStall_d;
            err_q         <= err_d;
        end
    end

    assign starve_stall = starveStall_q;
    assign err          = err_q;
`else
    assign grantWb      = wb_we;
    assign starve_stall = 1'b0;
    assign err          = 1'b0;
`endif

    // Pointer and occupancy update; simultaneous push and pop leave count alone.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (push) begin
            wrPtr_d = wrPtr_q + PW'(1);
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // WB wins the port, otherwise the FIFO head; with neither, only the
    // strobe drops and the data fields keep their last values.
    always_comb begin
        regWrite_d  = 1'b0;
        writeReg_d  = writeReg_q;
        writeData_d = writeData_q;
        pc8_d       = pc8_q;
        if (grantWb) begin
            regWrite_d  = 1'b1;
            writeReg_d  = wb_reg;
            writeData_d = wb_data;
            pc8_d       = wb_pc8;
        end else if (pop) begin
            regWrite_d  = 1'b1;
            writeReg_d  = fifoReg_q[rdPtr_q];
            writeData_d = fifoData_q[rdPtr_q];
            pc8_d       = fifoPc8_q[rdPtr_q];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            regWrite_q  <= 1'b0;
            writeReg_q  <= '0;
            writeData_q <= '0;
            pc8_q       <= '0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
            regWrite_q  <= regWrite_d;
            writeReg_q  <= writeReg_d;
            writeData_q <= writeData_d;
            pc8_q       <= pc8_d;
        end
    end

    // Entry contents need no reset; the count alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifoReg_q[wrPtr_q]  <= md_reg;
            fifoData_q[wrPtr_q] <= md_data;
            fifoPc8_q[wrPtr_q]  <= md_pc8;
        end
    end

    // A slot is live when its distance from the read pointer, modulo DEPTH,
    // is below the occupancy count.
    always_comb begin
        hit1   = 1'b0;
        hit2   = 1'b0;
        offset = '0;
        for (int j = 0; j < DEPTH; j++) begin
            offset = PW'(j) - rdPtr_q;
            if ({1'b0, offset} < count_q) begin
                if (fifoReg_q[j] == rd1) hit1 = 1'b1;
                if (fifoReg_q[j] == rd2) hit2 = 1'b1;
            end
        end
    end

    assign rd1_pending = (rd1 != 5'd0) && (hit1 || (regWrite_q && (writeReg_q == rd1)));
    assign rd2_pending = (rd2 != 5'd0) && (hit2 || (regWrite_q && (writeReg_q == rd2)));

    assign RegWrite  = regWrite_q;
    assign writereg  = writeReg_q;
    assign writedata = writeData_q;
    assign PC8       = pc8_q;

endmodule

// File: tb/tb_rf_wport_arb.sv
// ---------------------------------------------------------------------------
// tb_rf_wport_arb
//
// Self-checking bench for rf_wport_arb (DEPTH=2, STARVE_LIMIT=4). A
// queue-based reference model follows the arbitration rules: WB first,
// otherwise the oldest queued result, plus the starvation rule when
// RF_ARB_STARVE_GUARD_EN is defined. Directed scenarios come first, then a
// randomized run.
// ---------------------------------------------------------------------------
module tb_rf_wport_arb;

    localparam int DEPTH        = 2;
    localparam int STARVE_LIMIT = 4;

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
        logic [31:0] p;
    } entry_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_reg = '0;
    logic [31:0] wb_data = '0;
    logic [31:0] wb_pc8 = '0;
    logic        md_valid = 1'b0;
    logic [4:0]  md_reg = '0;
    logic [31:0] md_data = '0;
    logic [31:0] md_pc8 = '0;
    logic        md_ready;
    logic [4:0]  rd1 = '0;
    logic [4:0]  rd2 = '0;
    logic        rd1_pending;
    logic        rd2_pending;
    logic        starve_stall;
    logic        RegWrite;
    logic [4:0]  writereg;
    logic [31:0] writedata;
    logic [31:0] PC8;
    logic        err;

    int total = 0;
    int bad   = 0;

    // Reference model state
    entry_t      mq[$];
    logic        mRw;
    logic [4:0]  mReg;
    logic [31:0] mData;
    logic [31:0] mPc;
    logic        mStall;
    logic        mErr;
`ifdef RF_ARB_STARVE_GUARD_EN
    int          mStarve;
`endif

    rf_wport_arb #(
        .DEPTH       (DEPTH),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wb_we       (wb_we),
        .wb_reg      (wb_reg),
        .wb_data     (wb_data),
        .wb_pc8      (wb_pc8),
        .md_valid    (md_valid),
        .md_reg      (md_reg),
        .md_data     (md_data),
        .md_pc8      (md_pc8),
        .md_ready    (md_ready),
        .rd1         (rd1),
        .rd2         (rd2),
        .rd1_pending (rd1_pending),
        .rd2_pending (rd2_pending),
        .starve_stall(starve_stall),
        .RegWrite    (RegWrite),
        .writereg    (writereg),
        .writedata   (writedata),
        .PC8         (PC8),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Clear the model the same way reset clears the block: queue discarded.
    task automatic modelReset();
        mq.delete();
        mRw    = 1'b0;
        mReg   = '0;
        mData  = '0;
        mPc    = '0;
        mStall = 1'b0;
        mErr   = 1'b0;
`ifdef RF_ARB_STARVE_GUARD_EN
        mStarve = 0;
`endif
    endtask

    // One clock edge of the arbitration rules, using the inputs present at the edge.
    task automatic modelEdge();
        bit     grantWb;
        bit     popNow;
        bit     pushNow;
        int     sizeBefore;
        entry_t e;
        sizeBefore = mq.size();
        pushNow    = md_valid && (sizeBefore < DEPTH);
`ifdef RF_ARB_STARVE_GUARD_EN
        grantWb = wb_we && !mStall;
        if (wb_we && mStall) mErr = 1'b1;
`else
        grantWb = wb_we;
`endif
        popNow = !grantWb && (sizeBefore > 0);
        if (grantWb) begin
            mRw   = 1'b1;
            mReg  = wb_reg;
            mData = wb_data;
            mPc   = wb_pc8;
        end else if (popNow) begin
            e     = mq.pop_front();
            mRw   = 1'b1;
            mReg  = e.r;
            mData = e.d;
            mPc   = e.p;
        end else begin
            mRw = 1'b0;
        end
`ifdef RF_ARB_STARVE_GUARD_EN
        if (popNow || sizeBefore == 0) begin
            mStarve = 0;
            mStall  = 1'b0;
        end else begin
            mStarve = mStarve + 1;
            mStall  = (mStarve == STARVE_LIMIT);
        end
`endif
        if (pushNow) mq.push_back('{r: md_reg, d: md_data, p: md_pc8});
    endtask

    function automatic logic [72:0] expVec();
        return {mRw, mReg, mData, mPc, (mq.size() < DEPTH), mStall, mErr};
    endfunction

    function automatic logic expPend(input logic [4:0] rd);
        if (rd == 5'd0) return 1'b0;
        if (mRw && mReg == rd) return 1'b1;
        foreach (mq[i]) if (mq[i].r == rd) return 1'b1;
        return 1'b0;
    endfunction

    // Advance one edge; the model steps only when reset is released.
    task automatic step();
        @(posedge clk);
        if (reset) modelEdge();
        #1;
    endtask

    task automatic idleInputs();
        wb_we    = 1'b0;
        md_valid = 1'b0;
    endtask

    task automatic doReset();
        idleInputs();
        reset = 1'b0;
        modelReset();
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [72:0] obs;
        idleInputs();
        reset = 1'b0;
        modelReset();
        step();
        step();
        obs = {RegWrite, writereg, writedata, PC8, md_ready, starve_stall, err};
        total++;
        if (obs !== expVec()) begin
            bad++;
            $display("[TB] FAIL reset_state got=%h exp=%h", obs, expVec());
        end
        total++;
        if ({RegWrite, md_ready, starve_stall, err} !== 4'b0100) begin
            bad++;
            $display("[TB] FAIL reset_flags got=%b exp=0100", {RegWrite, md_ready, starve_stall, err});
        end
        reset = 1'b1;
        step();
        obs = {RegWrite, writereg, writedata, PC8, md_ready, starve_stall, err};
        total++;
        if (obs !== expVec()) begin
            bad++;
            $display("[TB] FAIL reset_release got=%h exp=%h", obs, expVec());
        end
    endtask

    task automatic test_idle_drain();
        logic [72:0] obs;
        idleInputs();
        md_valid = 1'b1;
        md_reg   = 5'd5;
        md_data  = 32'h1234;
        md_pc8   = 32'h3008;
        step();
        md_valid = 1'b0;
        total++;
        if (RegWrite !== 1'b0 || md_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL drain_no_bypass got=%b%b exp=01", RegWrite, md_ready);
        end
        step();
        obs = {RegWrite, writereg, writedata, PC8, md_ready, starve_stall, err};
        total++;
        if (obs !== expVec()) begin
            bad++;
            $display("[TB] FAIL drain_model got=%h exp=%h", obs, expVec());
        end
        total++;
        if ({RegWrite, writereg, writedata, PC8, md_ready} !== {1'b1, 5'd5, 32'h1234, 32'h3008, 1'b1}) begin
            bad++;
            $display("[TB] FAIL drain_write got=%b/%0d/%h/%h/%b exp=1/5/1234/3008/1",
                     RegWrite, writereg, writedata, PC8, md_ready);
        end
        step();
        total++;
        if (RegWrite !== 1'b0 || writereg !== 5'd5 || writedata !== 32'h1234) begin
            bad++;
            $display("[TB] FAIL drain_hold got=%b/%0d/%h exp=0/5/1234", RegWrite, writereg, writedata);
        end
    endtask

    task automatic test_simultaneous();
        idleInputs();
        md_valid = 1'b1;
        md_reg   = 5'd7;
        md_data  = 32'h7777;
        md_pc8   = 32'h0070;
        step();
        md_valid = 1'b0;
        wb_we    = 1'b1;
        wb_reg   = 5'd3;
        wb_data  = 32'hAAAA;
        wb_pc8   = 32'h0030;
        step();
        wb_we = 1'b0;
        total++;
        if ({RegWrite, writereg, writedata} !== {1'b1, 5'd3, 32'hAAAA}) begin
            bad++;
            $display("[TB] FAIL simul_wb_first got=%b/%0d/%h exp=1/3/aaaa", RegWrite, writereg, writedata);
        end
        step();
        total++;
        if ({RegWrite, writereg, writedata} !== {1'b1, 5'd7, 32'h7777} ||
            {RegWrite, writereg, writedata} !== {mRw, mReg, mData}) begin
            bad++;
            $display("[TB] FAIL simul_md_next got=%b/%0d/%h exp=1/7/7777", RegWrite, writereg, writedata);
        end
    endtask

    task automatic test_full();
        logic [72:0] obs;
        bit          willPush;
        idleInputs();
        wb_we    = 1'b1;
        wb_reg   = 5'd1;
        wb_data  = 32'h1000;
        md_valid = 1'b1;
        md_reg   = 5'd10;
        md_data  = 32'hA0;
        md_pc8   = 32'hA8;
        step();
        total++;
        if (md_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL full_one_entry got=%b exp=1", md_ready);
        end
        wb_data = 32'h1001;
        md_reg  = 5'd11;
        md_data = 32'hB0;
        md_pc8  = 32'hB8;
        step();
        total++;
        if (md_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL full_ready_low got=%b exp=0", md_ready);
        end
        wb_data = 32'h1002;
        md_reg  = 5'd12;
        md_data = 32'hC0;
        md_pc8  = 32'hC8;
        for (int k = 0; k < 10; k++) begin
            if (k >= 1) wb_we = 1'b0;
            willPush = md_valid && (mq.size() < DEPTH);
            step();
            if (willPush) md_valid = 1'b0;
            obs = {RegWrite, writereg, writedata, PC8, md_ready, starve_stall, err};
            total++;
            if (obs !== expVec()) begin
                bad++;
                $display("[TB] FAIL full_cycle%0d got=%h exp=%h", k, obs, expVec());
            end
        end
        total++;
        if (md_ready !== 1'b1 || md_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL full_third_accepted got=%b%b exp=10", md_ready, md_valid);
        end
    endtask

    task automatic test_starvation();
        logic [72:0] obs;
        doReset();
        wb_we    = 1'b1;
        wb_reg   = 5'd2;
        wb_data  = 32'h2222;
        md_valid = 1'b1;
        md_reg   = 5'd12;
        md_data  = 32'hC0DE;
        md_pc8   = 32'h0120;
        step();
        md_valid = 1'b0;
        for (int k = 0; k < STARVE_LIMIT; k++) begin
            wb_data = 32'h2300 + k;
            step();
            obs = {RegWrite, writereg, writedata, PC8, md_ready, starve_stall, err};
            total++;
            if (obs !== expVec()) begin
                bad++;
                $display("[TB] FAIL starve_deny%0d got=%h exp=%h", k, obs, expVec());
            end
        end
`ifdef RF_ARB_STARVE_GUARD_EN
        total++;
        if (starve_stall !== 1'b1) begin
            bad++;
            $display("[TB] FAIL starve_raise got=%b exp=1", starve_stall);
        end
`else
        total++;
        if (starve_stall !== 1'b0) begin
            bad++;
            $display("[TB] FAIL starve_tied got=%b exp=0", starve_stall);
        end
`endif
        wb_data = 32'hDEAD;
        step();
        obs = {RegWrite, writereg, writedata, PC8, md_ready, starve_stall, err};
        total++;
        if (obs !== expVec()) begin
            bad++;
            $display("[TB] FAIL starve_stall_cycle got=%h exp=%h", obs, expVec());
        end
`ifdef RF_ARB_STARVE_GUARD_EN
        total++;
        if ({RegWrite, writereg, writedata, starve_stall, err} !== {1'b1, 5'd12, 32'hC0DE, 1'b0, 1'b1}) begin
            bad++;
            $display("[TB] FAIL starve_forced got=%b/%0d/%h/%b/%b exp=1/12/c0de/0/1",
                     RegWrite, writereg, writedata, starve_stall, err);
        end
`endif
        wb_we = 1'b0;
        step();
        step();
        obs = {RegWrite, writereg, writedata, PC8, md_ready, starve_stall, err};
        total++;
        if (obs !== expVec()) begin
            bad++;
            $display("[TB] FAIL starve_after got=%h exp=%h", obs, expVec());
        end
    endtask

    task automatic test_pending_reset();
        logic [72:0] obs;
        idleInputs();
        step();
        step();
        step();
        wb_we    = 1'b1;
        wb_reg   = 5'd20;
        wb_data  = 32'h2020;
        md_valid = 1'b1;
        md_reg   = 5'd9;
        md_data  = 32'h9999;
        md_pc8   = 32'h0090;
        step();
        md_valid = 1'b0;
        rd1 = 5'd9;
        rd2 = 5'd0;
        #1;
        total++;
        if ({rd1_pending, rd2_pending} !== 2'b10 || rd1_pending !== expPend(rd1)) begin
            bad++;
            $display("[TB] FAIL pend_queued got=%b%b exp=10", rd1_pending, rd2_pending);
        end
        rd2 = 5'd20;
        #1;
        total++;
        if (rd2_pending !== 1'b1 || rd2_pending !== expPend(rd2)) begin
            bad++;
            $display("[TB] FAIL pend_issuing got=%b exp=1", rd2_pending);
        end
        reset = 1'b0;
        modelReset();
        #1;
        total++;
        if ({RegWrite, rd1_pending, md_ready} !== 3'b001) begin
            bad++;
            $display("[TB] FAIL pend_reset got=%b%b%b exp=001", RegWrite, rd1_pending, md_ready);
        end
        obs = {RegWrite, writereg, writedata, PC8, md_ready, starve_stall, err};
        total++;
        if (obs !== expVec()) begin
            bad++;
            $display("[TB] FAIL pend_reset_model got=%h exp=%h", obs, expVec());
        end
        wb_we = 1'b0;
        step();
        reset = 1'b1;
        step();
        total++;
        if (RegWrite !== 1'b0 || rd1_pending !== 1'b0) begin
            bad++;
            $display("[TB] FAIL pend_discard got=%b%b exp=00", RegWrite, rd1_pending);
        end
        wb_we   = 1'b1;
        wb_reg  = 5'd4;
        wb_data = 32'h4444;
        wb_pc8  = 32'h0044;
        step();
        wb_we = 1'b0;
        total++;
        if ({RegWrite, writereg, writedata, PC8} !== {1'b1, 5'd4, 32'h4444, 32'h0044}) begin
            bad++;
            $display("[TB] FAIL pend_resume got=%b/%0d/%h exp=1/4/4444", RegWrite, writereg, writedata);
        end
    endtask

    task automatic test_random();
        logic [72:0] obs;
        doReset();
        for (int c = 0; c < 400; c++) begin
            wb_we    = ($urandom_range(0, 9) < 7);
            wb_reg   = 5'($urandom_range(0, 7));
            wb_data  = $urandom;
            wb_pc8   = $urandom;
            md_valid = ($urandom_range(0, 9) < 4);
            md_reg   = 5'($urandom_range(0, 7));
            md_data  = $urandom;
            md_pc8   = $urandom;
            rd1      = 5'($urandom_range(0, 7));
            rd2      = 5'($urandom_range(0, 7));
            step();
            obs = {RegWrite, writereg, writedata, PC8, md_ready, starve_stall, err};
            total++;
            if (obs !== expVec()) begin
                bad++;
                $display("[TB] FAIL rand_port c=%0d got=%h exp=%h", c, obs, expVec());
            end
            total++;
            if ({rd1_pending, rd2_pending} !== {expPend(rd1), expPend(rd2)}) begin
                bad++;
                $display("[TB] FAIL rand_pend c=%0d got=%b%b exp=%b%b", c,
                         rd1_pending, rd2_pending, expPend(rd1), expPend(rd2));
            end
        end
        idleInputs();
    endtask

    initial begin
        modelReset();
        test_reset();
        test_idle_drain();
        test_simultaneous();
        test_full();
        test_starvation();
        test_pending_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
